uart_cmd_slave: RTL and testbench

//  UART command responder: the far end of the 2-frame command link driven by the uart command master.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_byte.sv | 82 ++++++++
 rtl/uart_cmd_slave.sv | 163 ++++++++++++++++
 tb/tb_uart_cmd_slave.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART command link: frame layout, parity mode,
// FSM state encoding and error-pulse bit positions.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 3;  // start + data + parity + stop

  // 0 = even parity, 1 = odd parity
  localparam logic PARITY_ODD = 1'b0;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_PARITY  = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_DATA = 3'd1,
    S_WRITE     = 3'd2,
    S_RD_REQ    = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_GAP       = 3'd5,
    S_TX        = 3'd6
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    return (^data) ^ PARITY_ODD;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, start detect with glitch rejection,
// mid-bit sampling, parity and stop checks. Re-arms right after the stop sample.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 active,
  output logic                 byte_vld,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [3:0]       IDX_PAR  = 4'(DATA_BITS + 1);

  logic                 rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;

  assign byte_data = shreg;

  // NOTE: the synchroniser resets to 1 (line idle) so leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      active     <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      par_q      <= 1'b0;
      byte_vld   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values, like real flops.
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_vld   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (!active) begin
        // Preloading half a period puts the first sample mid start bit.
        if (rx_prev && !rx_sync) begin
          active  <= 1'b1;
          cnt     <= CNT_HALF;
          bit_idx <= '0;
        end
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd0) begin
          if (rx_sync) active <= 1'b0;  // start bit gone at mid-point: glitch
        end else if (bit_idx < IDX_PAR) begin
          shreg <= {rx_sync, shreg[DATA_BITS-1:1]};
        end else if (bit_idx == IDX_PAR) begin
          par_q <= rx_sync;
        end else begin
          active <= 1'b0;
          if (!rx_sync)                      frame_err  <= 1'b1;
          else if (par_q != parity_bit(shreg)) parity_err <= 1'b1;
          else                               byte_vld   <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_slave.sv
// UART command responder: decodes {rw, addr} / data frames into register-bus
// writes and reads, and returns read data as one frame on tx.
module uart_cmd_slave
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int TX_GAP     = 2,
  parameter int IB_TIMEOUT = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic              tx,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rd_vld,
  output logic              busy,
  output logic [2:0]        err_pulse
);

  localparam int IB_CYCLES  = IB_TIMEOUT * CLK_DIV;
  localparam int GAP_CYCLES = TX_GAP * CLK_DIV;
  localparam int TMO_MAX0   = (IB_CYCLES > GAP_CYCLES) ? IB_CYCLES : GAP_CYCLES;
  localparam int TMO_MAX    = (TMO_MAX0 > RD_TIMEOUT) ? TMO_MAX0 : RD_TIMEOUT;
  localparam int TMO_W      = $clog2(TMO_MAX + 1);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TMO_W-1:0] IB_LAST  = TMO_W'(IB_CYCLES - 1);
  localparam logic [TMO_W-1:0] GAP_LAST = TMO_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] RD_LAST  = TMO_W'(RD_TIMEOUT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       IDX_LAST = 4'(FRAME_BITS - 1);

  state_t                state, state_next;
  logic                  rx_active, byte_vld, frame_err, parity_err;
  logic [DATA_BITS-1:0]  rx_byte;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  tmo_pulse, tmo_fire, rd_capture, tmo_clr, tx_bit_end;
  logic [DIV_W-1:0]      div_cnt;
  logic [3:0]            tx_idx;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [DATA_W-1:0]     tx_byte;

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .active     (rx_active),
    .byte_vld   (byte_vld),
    .byte_data  (rx_byte),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    tmo_fire   = 1'b0;
    rd_capture = 1'b0;
    tx_bit_end = (div_cnt == DIV_LAST);
    unique case (state)
      S_IDLE:
        if (byte_vld) state_next = rx_byte[7] ? S_WAIT_DATA : S_RD_REQ;
      S_WAIT_DATA:
        if (frame_err || parity_err) begin
          state_next = S_IDLE;
        end else if (byte_vld) begin
          state_next = S_WRITE;
        end else if (!rx_active && tmo_cnt == IB_LAST) begin
          tmo_fire   = 1'b1;
          state_next = S_IDLE;
        end
      S_WRITE:
        state_next = S_IDLE;
      S_RD_REQ:
        if (reg_rd_vld) begin
          rd_capture = 1'b1;
          state_next = S_GAP;
        end else begin
          state_next = S_RD_WAIT;
        end
      S_RD_WAIT:
        if (reg_rd_vld) begin
          rd_capture = 1'b1;
          state_next = S_GAP;
        end else if (tmo_cnt == RD_LAST) begin
          tmo_fire   = 1'b1;
          state_next = S_GAP;
        end
      S_GAP:
        if (tmo_cnt == GAP_LAST) state_next = S_TX;
      S_TX:
        if (tx_bit_end && tx_idx == IDX_LAST) state_next = S_IDLE;
      default:
        state_next = S_IDLE;
    endcase
  end

  // One counter serves the inter-byte, read-wait and gap intervals; it restarts
  // on every state change and while a write's data frame is being received.
  assign tmo_clr = (state_next != state) || (state == S_WAIT_DATA && rx_active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_byte   <= '0;
      tmo_cnt   <= '0;
      tmo_pulse <= 1'b0;
      div_cnt   <= '0;
      tx_idx    <= '0;
      tx_shift  <= '1;
    end else begin
      state     <= state_next;
      tmo_pulse <= tmo_fire;

      if (state == S_IDLE && byte_vld)      reg_addr  <= rx_byte[ADDR_W-1:0];
      if (state == S_WAIT_DATA && byte_vld) reg_wdata <= rx_byte;

      if (rd_capture)                           tx_byte <= reg_rdata;
      else if (tmo_fire && state == S_RD_WAIT)  tx_byte <= '1;

      if (tmo_clr)          tmo_cnt <= '0;
      else if (~&tmo_cnt)   tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state != S_TX) begin
        div_cnt <= '0;
        tx_idx  <= '0;
      end else if (tx_bit_end) begin
        div_cnt <= '0;
        tx_idx  <= tx_idx + 4'd1;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      // Shifting in ones leaves the line idle once the stop bit has gone out.
      if (state == S_GAP && state_next == S_TX)
        tx_shift <= {1'b1, parity_bit(tx_byte), tx_byte, 1'b0};
      else if (state == S_TX && tx_bit_end)
        tx_shift <= {1'b1, tx_shift[FRAME_BITS-1:1]};
    end
  end

  always_comb begin
    err_pulse              = '0;
    err_pulse[ERR_FRAME]   = frame_err;
    err_pulse[ERR_PARITY]  = parity_err;
    err_pulse[ERR_TIMEOUT] = tmo_pulse;
  end

  assign tx        = tx_shift[0];
  assign reg_wr_en = (state == S_WRITE);
  assign reg_rd_en = (state == S_RD_REQ);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave with CLK_DIV=16, TX_GAP=2: write, read,
// error and timeout cases, glitch rejection and reset during transmission.
module tb_uart_cmd_slave;

  localparam int CLK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       reg_rd_vld = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic       tx, reg_wr_en, reg_rd_en, busy;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [2:0] err_pulse;

  uart_cmd_slave #(.CLK_DIV(CLK_DIV), .TX_GAP(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .tx         (tx),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .reg_rd_vld (reg_rd_vld),
    .busy       (busy),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Event recorder sampled on the falling edge.
  int         cyc = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, busy_rises = 0, tx_low = 0;
  int         err_cyc = 0, rd_cyc = 0, busy_rise_cyc = 0;
  logic [2:0] last_err = '0;
  logic [6:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy_q = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reg_wr_en) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_rd_en) begin rd_cnt++; rd_cyc = cyc; rd_addr = reg_addr; end
    if (err_pulse != 3'b000) begin err_cnt++; last_err = err_pulse; err_cyc = cyc; end
    if (busy && !busy_q) begin busy_rises++; busy_rise_cyc = cyc; end
    if (!tx) tx_low++;
    busy_q = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop bit held for stop_cycles, then the line stays idle high.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic stop_val, input int stop_cycles);
    logic [10:0] f;
    f = {stop_val, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      tick((i == 10) ? stop_cycles : CLK_DIV);
    end
    rx = 1'b1;
  endtask

  task automatic get_tx_frame(output logic [10:0] f, output logic ok);
    int w;
    w = 0;
    while (tx && w < 2000) begin @(negedge clk); w++; end
    ok = !tx;
    tick(CLK_DIV / 2);
    for (int i = 0; i < 11; i++) begin
      f[i] = tx;
      if (i < 10) tick(CLK_DIV);
    end
  endtask

  initial begin
    logic [10:0] f;
    logic        ok, gap_ok;
    int          w, e0, wr0, rd0, b0, t0;

    // Reset state
    tick(5);
    check("rst_tx", tx, 1);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd_en", reg_rd_en, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_pulse, 0);
    rst_n = 1'b1;
    tick(5);

    // Write 0x85 (rw=1, addr=5) then data 0x3C
    t0 = tx_low;
    send_frame(8'h85, 1'b0, 1'b1, CLK_DIV);
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    w = 0;
    while (!reg_wr_en && w < 64) begin @(negedge clk); w++; end
    check("wr_strobe_seen", reg_wr_en, 1);
    check("wr_addr", reg_addr, 7'h05);
    check("wr_data", reg_wdata, 8'h3C);
    tick(1);
    check("wr_strobe_one_cycle", reg_wr_en, 0);
    tick(20);
    check("wr_count", wr_cnt, 1);
    check("wr_tx_idle", tx_low - t0, 0);
    check("wr_no_err", err_cnt, 0);
    check("wr_busy_done", busy, 0);

    // Read 0x12, data valid 3 cycles after the strobe
    send_frame(8'h12, 1'b0, 1'b1, 1);
    w = 0;
    while (!reg_rd_en && w < 64) begin @(negedge clk); w++; end
    check("rd_strobe_seen", reg_rd_en, 1);
    check("rd_addr", reg_addr, 7'h12);
    tick(3);
    reg_rd_vld = 1'b1;
    reg_rdata  = 8'hA7;
    gap_ok = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 1) reg_rd_vld = 1'b0;
      if (!tx) gap_ok = 1'b0;
    end
    check("rd_gap_idle_32", gap_ok, 1);
    @(negedge clk);
    check("rd_start_after_gap", tx, 0);
    tick(CLK_DIV / 2);
    for (int i = 0; i < 11; i++) begin
      f[i] = tx;
      if (i < 10) tick(CLK_DIV);
    end
    check("rd_frame_A7", f, 11'b1_1_10100111_0);
    tick(CLK_DIV);
    check("rd_count", rd_cnt, 1);
    check("rd_busy_done", busy, 0);

    // Bad parity on 0x85
    e0 = err_cnt; wr0 = wr_cnt; b0 = busy_rises;
    send_frame(8'h85, 1'b1, 1'b1, CLK_DIV);
    tick(4);
    check("par_err_count", err_cnt - e0, 1);
    check("par_err_value", last_err, 3'b010);
    check("par_no_busy", busy_rises - b0, 0);
    check("par_no_strobe", wr_cnt - wr0, 0);

    // Stop bit forced low on a read command byte
    e0 = err_cnt; rd0 = rd_cnt; b0 = busy_rises;
    send_frame(8'h55, 1'b0, 1'b0, CLK_DIV);
    tick(CLK_DIV);
    check("frm_err_count", err_cnt - e0, 1);
    check("frm_err_value", last_err, 3'b001);
    check("frm_idle", busy_rises - b0, 0);
    check("frm_no_strobe", rd_cnt - rd0, 0);

    // Write byte0 only -> inter-byte timeout after 256 cycles in wait
    e0 = err_cnt; wr0 = wr_cnt;
    send_frame(8'h85, 1'b0, 1'b1, 1);
    w = 0;
    while (err_cnt == e0 && w < 400) begin @(negedge clk); w++; end
    check("ib_tmo_value", last_err, 3'b100);
    check("ib_tmo_cycles", err_cyc - busy_rise_cyc, 256);
    check("ib_tmo_idle", busy, 0);
    tick(2);
    check("ib_tmo_no_strobe", wr_cnt - wr0, 0);

    // 4-cycle low glitch on rx
    e0 = err_cnt; b0 = busy_rises;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CLK_DIV);
    check("glitch_no_err", err_cnt - e0, 0);
    check("glitch_no_byte", busy_rises - b0, 0);

    // Read with no data valid -> 255-cycle wait, timeout pulse, 0xFF returned
    e0 = err_cnt;
    send_frame(8'h33, 1'b0, 1'b1, 1);
    get_tx_frame(f, ok);
    check("rdtmo_tx_started", ok, 1);
    check("rdtmo_frame_FF", f, 11'b1_0_11111111_0);
    check("rdtmo_err_value", last_err, 3'b100);
    check("rdtmo_cycles", err_cyc - rd_cyc, 256);
    check("rdtmo_addr", rd_addr, 7'h33);
    tick(CLK_DIV);

    // Same-cycle data valid, then reset during the start bit
    send_frame(8'h12, 1'b0, 1'b1, 1);
    w = 0;
    while (!reg_rd_en && w < 64) begin @(negedge clk); w++; end
    reg_rd_vld = 1'b1;
    reg_rdata  = 8'hA7;
    @(negedge clk);
    reg_rd_vld = 1'b0;
    w = 1;
    while (tx && w < 100) begin @(negedge clk); w++; end
    check("direct_rd_start_at", w, 33);
    tick(2);
    check("tx_start_driven", tx, 0);
    check("busy_in_tx", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", tx, 1);
    check("rst_async_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = tx_low;
    tick(3 * CLK_DIV);
    check("post_rst_tx_idle", tx_low - t0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
